// File: rtl/sr_ctrl_pkg.sv
// Shared types and defaults for the SR latch drive controller.
package sr_ctrl_pkg;

  localparam int DEF_PULSE_W = 2;
  localparam int DEF_GAP_W   = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE_S = 2'd1,
    DRIVE_R = 2'd2,
    GAP     = 2'd3
  } state_e;

  typedef enum logic {
    GRANT_S = 1'b0,
    GRANT_R = 1'b1
  } grant_e;

  // Counter width able to hold the larger of the two load values.
  function automatic int cnt_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sr_pulse_timer.sv
// Loadable down-counter with zero flag; times both the drive pulse and the gap.
module sr_pulse_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sr_latch_ctrl.sv
// Safe pulse sequencer for an SR latch with round-robin set/clear arbitration.
// Optional q_in readback check enabled by macro SR_LATCH_CTRL_VERIFY_EN.
module sr_latch_ctrl
  import sr_ctrl_pkg::*;
#(
  parameter int PULSE_W = DEF_PULSE_W,
  parameter int GAP_W   = DEF_GAP_W
) (
  input  logic clk,
  input  logic rst,
  input  logic set_req,
  input  logic clr_req,
  input  logic q_in,
  output logic s_n,
  output logic r_n,
  output logic ack_set,
  output logic ack_clr,
  output logic busy,
  output logic err
);

  localparam int CW = cnt_w(PULSE_W, GAP_W);

  state_e          state, state_nx;
  grant_e          last, last_nx;
  logic            tmr_load;
  logic [CW-1:0]   tmr_val;
  logic [CW-1:0]   tmr_cnt;
  logic            tmr_zero;

  sr_pulse_timer #(.W(CW)) u_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .cnt      (tmr_cnt),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_nx = state;
    last_nx  = last;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      IDLE: if (set_req || clr_req) begin
        if (set_req && clr_req) last_nx = (last == GRANT_S) ? GRANT_R : GRANT_S;
        else                    last_nx = set_req ? GRANT_S : GRANT_R;
        state_nx = (last_nx == GRANT_S) ? DRIVE_S : DRIVE_R;
        tmr_load = 1'b1;
        tmr_val  = CW'(PULSE_W - 1);
      end
      DRIVE_S, DRIVE_R: if (tmr_zero) begin
        state_nx = GAP;
        tmr_load = 1'b1;
        tmr_val  = CW'(GAP_W - 1);
      end
      GAP: if (tmr_zero) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Drives are registered off the next state so they never glitch low together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last  <= GRANT_R;
      s_n   <= 1'b1;
      r_n   <= 1'b1;
    end else begin
      state <= state_nx;
      last  <= last_nx;
      s_n   <= (state_nx != DRIVE_S);
      r_n   <= (state_nx != DRIVE_R);
    end
  end

  assign busy    = (state != IDLE);
  assign ack_set = (state == GAP) && tmr_zero && (last == GRANT_S);
  assign ack_clr = (state == GAP) && tmr_zero && (last == GRANT_R);

`ifdef SR_LATCH_CTRL_VERIFY_EN
  logic first_gap;
  assign first_gap = (state == GAP) && (tmr_cnt == CW'(GAP_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                           err <= 1'b0;
    else if (first_gap && (q_in != (last == GRANT_S))) err <= 1'b1;
  end
`else
  wire unused_vfy = q_in ^ (^tmr_cnt);
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Randomized self-checking bench for sr_latch_ctrl against a schedule-based model.
module tb_sr_latch_ctrl;

  localparam int P = 2;
  localparam int G = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic set_req = 1'b0, clr_req = 1'b0;
  logic q_in;
  logic s_n, r_n, ack_set, ack_clr, busy, err;

  int checks = 0;
  int errors = 0;

  sr_latch_ctrl #(.PULSE_W(P), .GAP_W(G)) dut (
    .clk(clk), .rst(rst), .set_req(set_req), .clr_req(clr_req), .q_in(q_in),
    .s_n(s_n), .r_n(r_n), .ack_set(ack_set), .ack_clr(ack_clr), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Behavioural latch seen by the controller; q_bad forces a stuck-low readback.
  logic q_lat = 1'b0;
  logic q_bad = 1'b0;
  always @(s_n or r_n) begin
    if (!s_n)      q_lat = 1'b1;
    else if (!r_n) q_lat = 1'b0;
  end
  assign q_in = q_bad ? 1'b0 : q_lat;

  // Model: each service is a grant edge plus P drive cycles then G gap cycles.
  bit mon_en = 0;
  int n = 0;
  bit m_act = 0, m_gs = 0, m_last_s = 0;
  int m_start = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n = 0; m_act = 0; m_last_s = 0;
    end else begin
      n++;
      if (m_act) begin
        if (n >= m_start + P + G) m_act = 0;
      end else if (set_req || clr_req) begin
        m_gs     = (set_req && clr_req) ? !m_last_s : set_req;
        m_last_s = m_gs;
        m_act    = 1;
        m_start  = n;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      logic drv, last_gap;
      logic [4:0] exp_v, got_v;
      drv      = m_act && (n < m_start + P);
      last_gap = m_act && (n == m_start + P + G - 1);
      exp_v = rst ? 5'b11000 :
              {!(drv && m_gs), !(drv && !m_gs), m_act, last_gap && m_gs, last_gap && !m_gs};
      got_v = {s_n, r_n, busy, ack_set, ack_clr};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL model cyc=%0d {s_n,r_n,busy,ack_s,ack_c} got=%b exp=%b", n, got_v, exp_v);
      end
      checks++;
      if ((s_n | r_n) !== 1'b1) begin
        errors++;
        $display("FAIL forbidden s_n=%b r_n=%b exp at least one high", s_n, r_n);
      end
`ifndef SR_LATCH_CTRL_VERIFY_EN
      checks++;
      if (err !== 1'b0) begin
        errors++;
        $display("FAIL err_const got=%b exp=0", err);
      end
`endif
    end
  end

  // Catch both-low drives between edges too (e.g. around async reset).
  always @(s_n or r_n) begin
    if (mon_en) begin
      checks++;
      if ((s_n | r_n) !== 1'b1) begin
        errors++;
        $display("FAIL forbidden_async s_n=%b r_n=%b", s_n, r_n);
      end
    end
  end

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; set_req = 1'b0; clr_req = 1'b0; q_bad = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    mon_en = 1;
    checks++;
    if ({s_n, r_n, busy, ack_set, ack_clr, err} !== 6'b110000) begin
      errors++;
      $display("FAIL reset_vals got=%b exp=110000", {s_n, r_n, busy, ack_set, ack_clr, err});
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if ({s_n, r_n, busy, ack_set, ack_clr} !== 5'b11000) begin
        errors++;
        $display("FAIL idle_after_reset k=%0d got=%b exp=11000", k, {s_n, r_n, busy, ack_set, ack_clr});
      end
    end
  endtask

  task automatic test_single_set();
    logic [3:0] sn_tab, ack_tab, busy_tab;
    sn_tab = 4'b1100; ack_tab = 4'b0100; busy_tab = 4'b0111;
    reset_dut();
    set_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({s_n, r_n, ack_set, ack_clr, busy} !== {sn_tab[k], 1'b1, ack_tab[k], 1'b0, busy_tab[k]}) begin
        errors++;
        $display("FAIL single_set k=%0d got=%b exp=%b", k, {s_n, r_n, ack_set, ack_clr, busy},
                 {sn_tab[k], 1'b1, ack_tab[k], 1'b0, busy_tab[k]});
      end
      if (ack_set) set_req = 1'b0;
    end
    checks++;
    if (q_in !== 1'b1) begin
      errors++;
      $display("FAIL single_set_q got=%b exp=1", q_in);
    end
  endtask

  task automatic test_drop_mid();
    int ack_k;
    reset_dut();
    clr_req = 1'b1;
    ack_k = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) clr_req = 1'b0;
      if (ack_clr && ack_k < 0) ack_k = k;
    end
    checks++;
    if (ack_k != P + G - 1) begin
      errors++;
      $display("FAIL drop_mid_ack cycle got=%0d exp=%0d", ack_k, P + G - 1);
    end
    checks++;
    if (q_in !== 1'b0) begin
      errors++;
      $display("FAIL drop_mid_q got=%b exp=0", q_in);
    end
  endtask

  task automatic test_round_robin();
    int gk[$];
    bit gs[$];
    logic ps, pr;
    reset_dut();
    set_req = 1'b1; clr_req = 1'b1;
    ps = 1'b1; pr = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (!s_n && ps) begin gk.push_back(k); gs.push_back(1'b1); end
      if (!r_n && pr) begin gk.push_back(k); gs.push_back(1'b0); end
      ps = s_n; pr = r_n;
    end
    set_req = 1'b0; clr_req = 1'b0;
    checks++;
    if (gk.size() != 4) begin
      errors++;
      $display("FAIL rr_count got=%0d exp=4", gk.size());
    end
    for (int i = 0; i < gk.size() && i < 4; i++) begin
      checks++;
      if (gs[i] !== ((i % 2) == 0) || gk[i] != 4 * i) begin
        errors++;
        $display("FAIL rr_grant i=%0d got set=%0b at %0d exp set=%0b at %0d",
                 i, gs[i], gk[i], ((i % 2) == 0), 4 * i);
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid_drive();
    reset_dut();
    clr_req = 1'b1;
    @(posedge clk); @(posedge clk);
    #2;
    checks++;
    if (r_n !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_pre r_n got=%b exp=0", r_n);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({r_n, s_n, busy, ack_clr, ack_set} !== 5'b11000) begin
      errors++;
      $display("FAIL rst_mid got=%b exp=11000", {r_n, s_n, busy, ack_clr, ack_set});
    end
    clr_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({ack_clr, ack_set, busy} !== 3'b000) begin
        errors++;
        $display("FAIL rst_mid_after k=%0d got=%b exp=000", k, {ack_clr, ack_set, busy});
      end
    end
  endtask

  task automatic test_random();
    reset_dut();
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (ack_set) set_req = 1'b0;
      else if (!set_req && ($urandom % 4) == 0) set_req = 1'b1;
      if (ack_clr) clr_req = 1'b0;
      else if (!clr_req && ($urandom % 4) == 0) clr_req = 1'b1;
    end
    set_req = 1'b0; clr_req = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_verify();
    bit seen;
    logic exp_err;
`ifdef SR_LATCH_CTRL_VERIFY_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    reset_dut();
    q_bad = 1'b1;
    set_req = 1'b1;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (ack_set) begin seen = 1; set_req = 1'b0; end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL verify_ack timeout got=0 exp=1");
    end
    q_bad = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (err !== exp_err) begin
      errors++;
      $display("FAIL verify_err got=%b exp=%b", err, exp_err);
    end
    clr_req = 1'b1;
    repeat (P + G + 1) @(negedge clk);
    clr_req = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (err !== exp_err) begin
      errors++;
      $display("FAIL verify_sticky got=%b exp=%b", err, exp_err);
    end
    reset_dut();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL verify_clear got=%b exp=0", err);
    end
  endtask

  initial begin
    test_reset();
    test_single_set();
    test_drop_mid();
    test_round_robin();
    test_reset_mid_drive();
    test_random();
    test_verify();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
